// File: rtl/huffman_pkg.sv
// Shared types and width helpers for the parametrised Huffman coder.
// Widths derived here are also used when the HUFF_LEN_EN length port is built.
package huffman_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        REPORT,
        MERGE,
        DONE
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int NSYM_DEF   = 6;
    localparam int CNT_W_DEF  = 8;
    localparam int CODE_W_DEF = 8;

    // Weights need room for NSYM saturated counts summed together.
    localparam int WGT_W_DEF  = CNT_W_DEF + clog2(NSYM_DEF);
    localparam int LEN_W_DEF  = clog2(CODE_W_DEF + 1);

endpackage

// File: rtl/huffman_min2.sv
// Combinational selector: indices of the two active entries with the
// smallest (weight, id) key; ties on weight resolve to the lower id.
module huffman_min2
    import huffman_pkg::*;
#(
    parameter int NSYM  = NSYM_DEF,
    parameter int WGT_W = WGT_W_DEF,
    parameter int IDX_W = clog2(NSYM_DEF)
) (
    input  logic [NSYM-1:0]       active_i,
    input  logic [NSYM*WGT_W-1:0] weight_i,
    input  logic [NSYM*IDX_W-1:0] id_i,
    output logic [IDX_W-1:0]      min1_o,
    output logic [IDX_W-1:0]      min2_o
);

    localparam int KEY_W = WGT_W + IDX_W;

    logic [KEY_W-1:0] key_cur;
    logic [KEY_W-1:0] key1;
    logic [KEY_W-1:0] key2;
    logic             found1;
    logic             found2;

    always_comb begin
        min1_o  = '0;
        min2_o  = '0;
        key_cur = '0;
        key1    = '1;
        key2    = '1;
        found1  = 1'b0;
        found2  = 1'b0;
        for (int i = 0; i < NSYM; i++) begin
            // Concatenated key gives the lexicographic (weight, id) order directly.
            key_cur = {weight_i[i*WGT_W +: WGT_W], id_i[i*IDX_W +: IDX_W]};
            if (active_i[i]) begin
                if (!found1 || key_cur < key1) begin
                    key2   = key1;
                    found2 = found1;
                    min2_o = min1_o;
                    key1   = key_cur;
                    found1 = 1'b1;
                    min1_o = IDX_W'(i);
                end else if (!found2 || key_cur < key2) begin
                    key2   = key_cur;
                    found2 = 1'b1;
                    min2_o = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/huffman_param.sv
// Parametrised Huffman coder: counts a symbol frame, then builds codes with
// one two-group merge per cycle. Define HUFF_LEN_EN to add the len_bus port.
//
// state  | meaning
// IDLE   | waiting for the first symbol of a frame
// COUNT  | accumulating symbol counts while gray_valid is high
// REPORT | counts final (CNT_valid), groups initialised
// MERGE  | NSYM-1 cycles, one merge of the two lightest groups each
// DONE   | results held; a valid symbol starts the next frame
module huffman_param
    import huffman_pkg::*;
#(
    parameter int NSYM   = NSYM_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   gray_valid,
    input  logic [7:0]             gray_data,
    output logic                   CNT_valid,
    output logic [NSYM*CNT_W-1:0]  cnt_bus,
    output logic                   code_valid,
    output logic [NSYM*CODE_W-1:0] hc_bus,
    output logic [NSYM*CODE_W-1:0] m_bus
`ifdef HUFF_LEN_EN
    ,
    output logic [NSYM*clog2(CODE_W+1)-1:0] len_bus
`endif
);

    localparam int WGT_W = CNT_W + clog2(NSYM);
    localparam int IDX_W = clog2(NSYM);

    if (CODE_W < NSYM - 1 || NSYM < 2 || NSYM > 16) begin : g_bad_param
        $error("huffman_param: need 2 <= NSYM <= 16 and CODE_W >= NSYM-1");
    end

    state_e state_q, state_d;

    logic [CNT_W-1:0]  cnt_q  [NSYM];
    logic [CODE_W-1:0] hc_q   [NSYM];
    logic [CODE_W-1:0] m_q    [NSYM];
    logic [IDX_W-1:0]  grp_q  [NSYM];
    logic [WGT_W-1:0]  wgt_q  [NSYM];
    logic [NSYM-1:0]   act_q;
    logic [IDX_W-1:0]  iter_q;
    logic              cnt_valid_q;
    logic              code_valid_q;

    logic [CODE_W-1:0]      nxt_bit [NSYM];
    logic [NSYM*WGT_W-1:0]  wgt_flat;
    logic [NSYM*IDX_W-1:0]  id_flat;
    logic [IDX_W-1:0]       min1, min2, keep, drop;
    logic                   frame_start;

    assign frame_start = gray_valid && (state_q == IDLE || state_q == DONE);
    assign keep        = (min1 < min2) ? min1 : min2;
    assign drop        = (min1 < min2) ? min2 : min1;

    // Masks are contiguous from bit 0, so their popcount is the next code position.
    always_comb begin
        for (int s = 0; s < NSYM; s++) begin
            nxt_bit[s] = CODE_W'(1) << $countones(m_q[s]);
        end
    end

    for (genvar g = 0; g < NSYM; g++) begin : g_flat
        assign wgt_flat[g*WGT_W +: WGT_W]   = wgt_q[g];
        assign id_flat[g*IDX_W +: IDX_W]    = IDX_W'(g);
        assign cnt_bus[g*CNT_W +: CNT_W]    = cnt_q[g];
        assign hc_bus[g*CODE_W +: CODE_W]   = hc_q[g];
        assign m_bus[g*CODE_W +: CODE_W]    = m_q[g];
    end

    huffman_min2 #(
        .NSYM  (NSYM),
        .WGT_W (WGT_W),
        .IDX_W (IDX_W)
    ) u_min2 (
        .active_i (act_q),
        .weight_i (wgt_flat),
        .id_i     (id_flat),
        .min1_o   (min1),
        .min2_o   (min2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (gray_valid) state_d = COUNT;
            COUNT:      if (!gray_valid) state_d = REPORT;
            REPORT:     state_d = MERGE;
            MERGE:      if (iter_q == IDX_W'(1)) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NSYM; s++) begin
                cnt_q[s] <= '0;
                hc_q[s]  <= '0;
                m_q[s]   <= '0;
                grp_q[s] <= '0;
                wgt_q[s] <= '0;
            end
            act_q        <= '0;
            iter_q       <= '0;
            cnt_valid_q  <= 1'b0;
            code_valid_q <= 1'b0;
        end else begin
            cnt_valid_q  <= (state_q == COUNT) && !gray_valid;
            code_valid_q <= (state_q == MERGE) && (iter_q == IDX_W'(1));
            if (frame_start) begin
                for (int s = 0; s < NSYM; s++) begin
                    cnt_q[s] <= (gray_data == 8'(s + 1)) ? CNT_W'(1) : '0;
                    hc_q[s]  <= '0;
                    m_q[s]   <= '0;
                end
            end else if (state_q == COUNT && gray_valid) begin
                for (int s = 0; s < NSYM; s++) begin
                    if (gray_data == 8'(s + 1) && cnt_q[s] != '1) cnt_q[s] <= cnt_q[s] + 1'b1;
                end
            end else if (state_q == REPORT) begin
                for (int s = 0; s < NSYM; s++) begin
                    grp_q[s] <= IDX_W'(s);
                    wgt_q[s] <= {{(WGT_W-CNT_W){1'b0}}, cnt_q[s]};
                end
                act_q  <= '1;
                iter_q <= IDX_W'(NSYM - 1);
            end else if (state_q == MERGE) begin
                // Surviving group keeps the lower id, i.e. the lower slot.
                wgt_q[keep] <= wgt_q[min1] + wgt_q[min2];
                act_q[drop] <= 1'b0;
                iter_q      <= iter_q - 1'b1;
                for (int s = 0; s < NSYM; s++) begin
                    if (grp_q[s] == min1) begin
                        hc_q[s] <= hc_q[s] | nxt_bit[s];
                        m_q[s]  <= m_q[s] | nxt_bit[s];
                    end
                    if (grp_q[s] == min2) m_q[s] <= m_q[s] | nxt_bit[s];
                    if (grp_q[s] == drop) grp_q[s] <= keep;
                end
            end
        end
    end

    assign CNT_valid  = cnt_valid_q;
    assign code_valid = code_valid_q;

`ifdef HUFF_LEN_EN
    localparam int LEN_W = clog2(CODE_W + 1);

    logic [LEN_W-1:0] len_q [NSYM];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NSYM; s++) len_q[s] <= '0;
        end else if (frame_start) begin
            for (int s = 0; s < NSYM; s++) len_q[s] <= '0;
        end else if (state_q == MERGE) begin
            for (int s = 0; s < NSYM; s++) begin
                if (grp_q[s] == min1 || grp_q[s] == min2) len_q[s] <= len_q[s] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NSYM; g++) begin : g_len
        assign len_bus[g*LEN_W +: LEN_W] = len_q[g];
    end
`endif

endmodule

// File: tb/tb_huffman_param.sv
// Scoreboard bench for huffman_param: a 6-symbol and a 4-symbol instance;
// stimulus pushes expected results, a single monitor pops and compares.
module tb_huffman_param;

    typedef struct {
        logic [47:0] hc;
        logic [47:0] m;
        logic [23:0] len;
    } code6_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        v6, v4;
    logic [7:0]  d6, d4;
    logic        cv6, kv6, cv4, kv4;
    logic [47:0] cnt6, hc6, m6;
    logic [31:0] cnt4, hc4, m4;
    logic [23:0] len6;
    logic [15:0] len4;

    always #5 clk = ~clk;

    huffman_param #(.NSYM(6), .CNT_W(8), .CODE_W(8)) dut6 (
        .clk(clk), .reset(reset), .gray_valid(v6), .gray_data(d6),
        .CNT_valid(cv6), .cnt_bus(cnt6), .code_valid(kv6), .hc_bus(hc6), .m_bus(m6)
`ifdef HUFF_LEN_EN
        , .len_bus(len6)
`endif
    );

    huffman_param #(.NSYM(4), .CNT_W(8), .CODE_W(8)) dut4 (
        .clk(clk), .reset(reset), .gray_valid(v4), .gray_data(d4),
        .CNT_valid(cv4), .cnt_bus(cnt4), .code_valid(kv4), .hc_bus(hc4), .m_bus(m4)
`ifdef HUFF_LEN_EN
        , .len_bus(len4)
`endif
    );

`ifndef HUFF_LEN_EN
    assign len6 = '0;
    assign len4 = '0;
`endif

    logic [47:0] exp_cnt6 [$];
    code6_t      exp_code6 [$];
    logic [31:0] exp_cnt4 [$];
    logic [31:0] exp_hc4 [$];
    logic [31:0] exp_m4 [$];
    logic [7:0]  stim_q [$];

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_cnt6 = 0;
    int    zero_req = 0, zero_seen = 0;
    int    tmo_req = 0, tmo_seen = 0;
    bit    done_req = 1'b0;
    string tmo_name = "";

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [47:0] p6(input logic [7:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    function automatic logic [23:0] l6(input logic [3:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    task automatic push6(input logic [47:0] cnt, input logic [47:0] hc, input logic [47:0] m,
                         input logic [23:0] len);
        code6_t c;
        c.hc = hc; c.m = m; c.len = len;
        exp_cnt6.push_back(cnt);
        exp_code6.push_back(c);
    endtask

    task automatic add(input logic [7:0] sym, input int n);
        repeat (n) stim_q.push_back(sym);
    endtask

    task automatic load_s1();
        add(8'd1, 1); add(8'd2, 1); add(8'd3, 2); add(8'd4, 4); add(8'd5, 8); add(8'd6, 16);
    endtask

    // Called at a falling edge; returns at the falling edge of the CNT_valid cycle.
    task automatic send(input bit to4);
        logic [7:0] s;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            if (to4) begin v4 = 1'b1; d4 = s; end
            else     begin v6 = 1'b1; d6 = s; end
            @(negedge clk);
        end
        v4 = 1'b0;
        v6 = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_code(input bit on4, input string name);
        int n;
        n = 0;
        while (!(on4 ? kv4 : kv6) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            tmo_name = name;
            tmo_req++;
        end
    endtask

    // Monitor: the only process that compares and counts.
    initial begin
        code6_t ec;
        logic [47:0] e48;
        forever begin
            @(negedge clk);
            if (zero_req != zero_seen) begin
                zero_seen = zero_req;
                checks++;
                if (cv6 !== 1'b0 || kv6 !== 1'b0 || cnt6 !== '0 || hc6 !== '0 || m6 !== '0 ||
                    len6 !== '0 || cnt4 !== '0 || hc4 !== '0 || m4 !== '0) begin
                    errors++;
                    $display("FAIL reset_zero got cv=%b kv=%b cnt=%h hc=%h m=%h len=%h cnt4=%h want all 0",
                             cv6, kv6, cnt6, hc6, m6, len6, cnt4);
                end
            end
            if (tmo_req != tmo_seen) begin
                tmo_seen = tmo_req;
                checks++;
                errors++;
                $display("FAIL timeout_%s got no code_valid want a pulse within 40 cycles", tmo_name);
            end
            if (cv6) begin
                checks++;
                last_cnt6 = cyc;
                if (exp_cnt6.size() == 0) begin
                    errors++;
                    $display("FAIL cnt6_unexpected got CNT_valid cnt=%h want no pulse", cnt6);
                end else begin
                    e48 = exp_cnt6.pop_front();
                    if (cnt6 !== e48) begin
                        errors++;
                        $display("FAIL cnt6 got %h want %h", cnt6, e48);
                    end
                end
            end
            if (kv6) begin
                checks++;
                if (exp_code6.size() == 0) begin
                    errors++;
                    $display("FAIL code6_unexpected got code_valid hc=%h want no pulse", hc6);
                end else begin
                    ec = exp_code6.pop_front();
                    if (hc6 !== ec.hc) begin
                        errors++;
                        $display("FAIL hc6 got %h want %h", hc6, ec.hc);
                    end
                    checks++;
                    if (m6 !== ec.m) begin
                        errors++;
                        $display("FAIL m6 got %h want %h", m6, ec.m);
                    end
`ifdef HUFF_LEN_EN
                    checks++;
                    if (len6 !== ec.len) begin
                        errors++;
                        $display("FAIL len6 got %h want %h", len6, ec.len);
                    end
`endif
                    checks++;
                    if (cyc - last_cnt6 != 6) begin
                        errors++;
                        $display("FAIL latency6 got %0d want 6 cycles CNT_valid->code_valid", cyc - last_cnt6);
                    end
                end
            end
            if (cv4) begin
                checks++;
                if (exp_cnt4.size() == 0 || cnt4 !== exp_cnt4[0]) begin
                    errors++;
                    $display("FAIL cnt4 got %h want %h", cnt4, exp_cnt4.size() ? exp_cnt4[0] : 32'hx);
                end
                if (exp_cnt4.size() != 0) void'(exp_cnt4.pop_front());
            end
            if (kv4) begin
                checks++;
                if (exp_hc4.size() == 0 || exp_m4.size() == 0) begin
                    errors++;
                    $display("FAIL code4_unexpected got hc=%h want no pulse", hc4);
                end else begin
                    if (hc4 !== exp_hc4[0]) begin
                        errors++;
                        $display("FAIL hc4 got %h want %h", hc4, exp_hc4[0]);
                    end
                    checks++;
                    if (m4 !== exp_m4[0]) begin
                        errors++;
                        $display("FAIL m4 got %h want %h", m4, exp_m4[0]);
                    end
                    void'(exp_hc4.pop_front());
                    void'(exp_m4.pop_front());
                end
            end
            if (done_req) begin
                checks++;
                if (exp_cnt6.size() != 0 || exp_code6.size() != 0 || exp_cnt4.size() != 0 ||
                    exp_hc4.size() != 0) begin
                    errors++;
                    $display("FAIL leftover got cnt6=%0d code6=%0d cnt4=%0d code4=%0d pending want 0",
                             exp_cnt6.size(), exp_code6.size(), exp_cnt4.size(), exp_hc4.size());
                end
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no end of test want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        v6 = 1'b0; d6 = 8'd0;
        v4 = 1'b0; d4 = 8'd0;
        @(negedge clk);
        #1 zero_req++;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        // Powers-of-two weights: one extra code bit per level.
        push6(p6(8'd1, 8'd1, 8'd2, 8'd4, 8'd8, 8'd16),
              p6(8'h1F, 8'h1E, 8'h0E, 8'h06, 8'h02, 8'h00),
              p6(8'h1F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01),
              l6(4'd5, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1));
        load_s1();
        send(1'b0);
        wait_code(1'b0, "s1");
        @(negedge clk);

        // Equal weights: tie rule on the 4-symbol instance.
        exp_cnt4.push_back(32'h05050505);
        exp_hc4.push_back(32'h00010203);
        exp_m4.push_back(32'h03030303);
        for (int r = 0; r < 5; r++) begin
            add(8'd1, 1); add(8'd2, 1); add(8'd3, 1); add(8'd4, 1);
        end
        send(1'b1);
        wait_code(1'b1, "tie4");
        @(negedge clk);

        // Saturation plus out-of-range IDs.
        push6(p6(8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0),
              p6(8'h1F, 8'h1E, 8'h00, 8'h0E, 8'h06, 8'h02),
              p6(8'h1F, 8'h1F, 8'h01, 8'h0F, 8'h07, 8'h03),
              l6(4'd5, 4'd5, 4'd1, 4'd4, 4'd3, 4'd2));
        for (int i = 0; i < 300; i++) begin
            add(8'd3, 1);
            if (i % 60 == 30) add(8'd0, 1);
            if (i % 90 == 45) add(8'd9, 1);
        end
        send(1'b0);
        wait_code(1'b0, "sat");
        @(negedge clk);

        // Single-symbol frame.
        push6(p6(8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0),
              p6(8'h1F, 8'h1E, 8'h0E, 8'h00, 8'h06, 8'h02),
              p6(8'h1F, 8'h1F, 8'h0F, 8'h01, 8'h07, 8'h03),
              l6(4'd5, 4'd5, 4'd4, 4'd1, 4'd3, 4'd2));
        add(8'd4, 1);
        send(1'b0);
        wait_code(1'b0, "one");
        @(negedge clk);

        // Abort in the third MERGE cycle: counts reported, no codes.
        exp_cnt6.push_back(p6(8'd1, 8'd1, 8'd2, 8'd4, 8'd8, 8'd16));
        load_s1();
        send(1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1 zero_req++;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);

        push6(p6(8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0),
              p6(8'h02, 8'h00, 8'h1F, 8'h1E, 8'h0E, 8'h06),
              p6(8'h03, 8'h01, 8'h1F, 8'h1F, 8'h0F, 8'h07),
              l6(4'd2, 4'd1, 4'd5, 4'd5, 4'd4, 4'd3));
        add(8'd2, 1); add(8'd1, 1); add(8'd2, 1);
        send(1'b0);
        wait_code(1'b0, "after_abort");
        @(negedge clk);

        // Back-to-back: second frame starts in the first frame's code_valid cycle.
        push6(p6(8'd1, 8'd1, 8'd2, 8'd4, 8'd8, 8'd16),
              p6(8'h1F, 8'h1E, 8'h0E, 8'h06, 8'h02, 8'h00),
              p6(8'h1F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01),
              l6(4'd5, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1));
        push6(p6(8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2),
              p6(8'h1F, 8'h1E, 8'h0E, 8'h06, 8'h02, 8'h00),
              p6(8'h1F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01),
              l6(4'd5, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1));
        load_s1();
        send(1'b0);
        wait_code(1'b0, "b2b_a");
        add(8'd6, 1); add(8'd5, 1); add(8'd6, 1);
        send(1'b0);
        wait_code(1'b0, "b2b_b");
        repeat (3) @(negedge clk);
        done_req = 1'b1;
    end

endmodule

// File: doc/huffman_param.md
# huffman_param

Parametrised Huffman coder. It takes a stream of symbol IDs in the range 1..NSYM, counts how often each occurs, and publishes the counts. It then runs one merge of the two lightest groups per cycle and publishes a prefix code and bit mask for every symbol. This is the next-generation replacement for the fixed six-symbol coder: symbol count and widths are parameters, counts saturate, and the block takes back-to-back frames without a reset.

## Interface
- NSYM, 6: number of symbols, 2..16; symbol IDs run 1..NSYM.
- CNT_W, 8: width of each count.
- CODE_W, 8: width of each code and mask; must be ≥ NSYM-1, elaboration error otherwise.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- gray_valid  in  1  gray_data is a valid symbol this cycle.
- gray_data  in  8  symbol ID.
- CNT_valid  out  1  one-cycle pulse: cnt_bus is final for the frame.
- cnt_bus  out  NSYM*CNT_W  count of symbol i in slice [(i-1)*CNT_W +: CNT_W].
- code_valid  out  1  one-cycle pulse: hc_bus and m_bus are final.
- hc_bus  out  NSYM*CODE_W  code of symbol i, LSB-aligned.
- m_bus  out  NSYM*CODE_W  mask of symbol i: ones over the valid code bits.

## Operation
- States: IDLE → COUNT → REPORT → MERGE → DONE. DONE behaves like IDLE for starting a new frame.
- Frame start: a cycle with gray_valid=1 while in IDLE or DONE.
  - Clears all counts, codes and masks.
  - Counts that first symbol.
  - Goes to COUNT.
- COUNT: each cycle with gray_valid=1 increments the count of symbol gray_data.
  - Counts saturate at 2^CNT_W-1.
  - IDs equal to 0 or greater than NSYM are ignored.
  - The first cycle with gray_valid=0 goes to REPORT.
- REPORT, one cycle:
  - CNT_valid=1.
  - Initialises groups: group i = {symbol i}, weight = count i, id = i.
  - Goes to MERGE.
- MERGE: NSYM-1 iterations, one per cycle. Each iteration:
  - Selects the two active groups with the smallest (weight, id), compared lexicographically, so ties go to the lower id. min1 is the smallest, min2 the next.
  - Every symbol in min1 gets bit 1 and every symbol in min2 gets bit 0, placed at bit position len, where len is that symbol's current code length. The mask bit at that position is set and len is incremented.
  - The merged group takes id = min(id1, id2) and weight = w1 + w2. The other group is deactivated.
  - Weights are CNT_W + clog2(NSYM) bits wide, so sums never overflow.
  - Zero-count symbols take part like any other.
- DONE:
  - code_valid=1 for one cycle on entry.
  - cnt_bus, hc_bus and m_bus hold until the next frame start.
- gray_valid is ignored in REPORT and MERGE.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- A symbol is sampled on the rising edge where gray_valid=1. cnt_bus reflects it in the next cycle.
- Let edge t be the one that samples gray_valid=0 in COUNT.
  - CNT_valid is high in cycle t+1.
  - code_valid is high in cycle t+1+NSYM.
- A frame start can occur in the same cycle code_valid is high. It takes effect at that edge, so there are zero dead cycles between frames.
- Reset asserted mid-frame aborts the frame immediately. No pulse is produced for the aborted frame.
- A one-symbol frame (gray_valid high for a single cycle) is legal and gives the same latency.

## Configuration
- HUFF_LEN_EN defined:
  - Adds output port len_bus (NSYM*clog2(CODE_W+1) bits) holding each symbol's code length.
  - len_bus is valid with code_valid, resets to 0, and clears on frame start.
- HUFF_LEN_EN undefined: the port and its registers are absent. Lengths can be recovered from m_bus.

## Structure
- Package huffman_pkg holds:
  - the state enum (IDLE, COUNT, REPORT, MERGE, DONE);
  - a constant function clog2;
  - the derived-width localparams (weight width, length width).
- Sub-module huffman_min2: a combinational selector over NSYM (active, weight, id) entries that returns the indices of min1 and min2 with the lower-id tie rule.
- The top level holds the counters, group-id registers, code/mask/len registers and the FSM.

## Test plan
- NSYM=6, counts s1..s6 = 1,1,2,4,8,16:
  - CNT_valid shows 1,1,2,4,8,16.
  - Codes: HC = 1F,1E,0E,06,02,00.
  - Masks: M = 1F,1F,0F,07,03,01.
  - code_valid comes 6 cycles after CNT_valid.
- NSYM=4, each symbol 5 times: HC = 3,2,1,0 and all M = 3. This checks the tie rule.
- Symbol 3 sent 300 times, plus IDs 0 and 9 mixed in (NSYM=6): cnt3 = 255 (saturated); the out-of-range IDs change nothing.
- Reset asserted during the third MERGE cycle: all outputs read 0 on the next cycle and no code_valid occurs. A following frame completes normally.
- Two frames back-to-back, the second starting in the code_valid cycle:
  - The second frame's counts start from the cleared state.
  - The first frame's codes are observed intact in its code_valid cycle.
- With HUFF_LEN_EN defined, repeat the first scenario: len_bus = 5,5,4,3,2,1.
